zero_stuff_serializer: RTL and testbench

Sequential front end for the zero-insertion datapath: accepts one WIDTH-bit word per handshake and streams it out one bit per cycle, MSB first, inserting a 0 between every pair of adjacent 1s. Output order and content match the combinational zero-insert rule: 10111 becomes 1010101, and 11111 becomes 101010101. It sits between a word-wide producer and a serial line driver, so the serial output never carries "11".

---
 rtl/zero_stuff_pkg.sv | 25 ++
 rtl/zero_stuff_pair_detect.sv | 11 +
 rtl/zero_stuff_serializer.sv | 119 +++++++++++
 tb/tb_zero_stuff_serializer.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/zero_stuff_pkg.sv
// Shared types and helpers for the zero-stuffing serializer slice.
package zero_stuff_pkg;

    localparam int DEFAULT_WIDTH = 5;
    localparam int MAX_WIDTH     = 32;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        STUFF
    } state_t;

    // Zero-extending a narrower word adds no 1-1 pairs, so one fixed width serves every WIDTH.
    function automatic int unsigned stuff_count(input logic [MAX_WIDTH-1:0] word);
        int unsigned n;
        n = 0;
        for (int i = 0; i < MAX_WIDTH - 1; i++) begin
            if (word[i+1] && word[i]) begin
                n = n + 1;
            end
        end
        return n;
    endfunction

endpackage

// File: rtl/zero_stuff_pair_detect.sv
// Flags every adjacent pair of ones in a word: mask[i] = word[i+1] & word[i].
module zero_stuff_pair_detect #(
    parameter int WIDTH = 5
) (
    input  logic [WIDTH-1:0] word,
    output logic [WIDTH-2:0] mask
);

    assign mask = word[WIDTH-1:1] & word[WIDTH-2:0];

endmodule

// File: rtl/zero_stuff_serializer.sv
// Word-in, bit-out serializer that inserts a 0 between adjacent 1s, MSB first.
// Optional stuff_cnt output is enabled by defining ZERO_STUFF_COUNT_EN.
module zero_stuff_serializer
    import zero_stuff_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_bit,
    output logic             out_last,
    output logic             busy
`ifdef ZERO_STUFF_COUNT_EN
    ,
    output logic [$clog2(WIDTH)-1:0] stuff_cnt
`endif
);

    localparam int IDX_W = $clog2(WIDTH);
    localparam int PAD_W = 1 << IDX_W;

    state_t           state;
    logic [WIDTH-1:0] word_q;
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] idx_m1;
    logic [WIDTH-2:0] mask;
    logic [PAD_W-1:0] mask_pad;
    logic             accept;
    logic             xfer;

    zero_stuff_pair_detect #(.WIDTH(WIDTH)) u_pair_detect (
        .word (word_q),
        .mask (mask)
    );

    // Padding lets the mask be indexed with the full idx width.
    assign mask_pad = PAD_W'(mask);
    assign idx_m1   = idx - IDX_W'(1);
    assign accept   = in_valid && in_ready;
    assign xfer     = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            word_q    <= '0;
            idx       <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_bit   <= 1'b0;
            out_last  <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        state     <= DATA;
                        word_q    <= in_data;
                        idx       <= IDX_W'(WIDTH - 1);
                        in_ready  <= 1'b0;
                        out_valid <= 1'b1;
                        out_bit   <= in_data[WIDTH-1];
                        out_last  <= 1'b0;
                        busy      <= 1'b1;
                    end
                end
                DATA: begin
                    if (xfer) begin
                        if (idx == '0) begin
                            state     <= IDLE;
                            in_ready  <= 1'b1;
                            out_valid <= 1'b0;
                            out_last  <= 1'b0;
                            busy      <= 1'b0;
                        end else if (mask_pad[idx_m1]) begin
                            state    <= STUFF;
                            out_bit  <= 1'b0;
                            out_last <= 1'b0;
                        end else begin
                            idx      <= idx_m1;
                            out_bit  <= word_q[idx_m1];
                            out_last <= (idx_m1 == '0);
                        end
                    end
                end
                STUFF: begin
                    if (xfer) begin
                        state    <= DATA;
                        idx      <= idx_m1;
                        out_bit  <= word_q[idx_m1];
                        out_last <= (idx_m1 == '0);
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                    out_last  <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

`ifdef ZERO_STUFF_COUNT_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stuff_cnt <= '0;
        end else if (state == IDLE && accept) begin
            stuff_cnt <= IDX_W'(stuff_count(MAX_WIDTH'(in_data)));
        end
    end
`endif

endmodule

// File: tb/tb_zero_stuff_serializer.sv
// Randomized self-checking bench for zero_stuff_serializer against a "never emit 11" reference model.
// Honours ZERO_STUFF_COUNT_EN to also check stuff_cnt.
module tb_zero_stuff_serializer;

    localparam int W = 5;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic         out_bit;
    logic         out_last;
    logic         busy;
`ifdef ZERO_STUFF_COUNT_EN
    logic [$clog2(W)-1:0] stuff_cnt;
`endif

    int vectors     = 0;
    int miscompares = 0;
    bit expBits[$];

    zero_stuff_serializer #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_bit   (out_bit),
        .out_last  (out_last),
        .busy      (busy)
`ifdef ZERO_STUFF_COUNT_EN
        ,
        .stuff_cnt (stuff_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference: emit MSB first, and whenever a 1 would follow a 1 on the line, put a 0 in between.
    task automatic buildExpected(input logic [W-1:0] word);
        bit prev;
        expBits.delete();
        prev = 1'b0;
        for (int i = W - 1; i >= 0; i--) begin
            if (word[i] && prev) expBits.push_back(1'b0);
            expBits.push_back(word[i]);
            prev = word[i];
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // mode 0: out_ready always high, 1: pattern 1,0,0,1 repeating, 2: random stalls
    task automatic applyStimulus(input logic [W-1:0] word, input int mode, input bit holdValid);
        int  j;
        int  cyc;
        int  waitCyc;
        bit  r;
        bit  pattern[4];
        pattern = '{1'b1, 1'b0, 1'b0, 1'b1};
        buildExpected(word);

        waitCyc = 0;
        while (!in_ready && waitCyc < 50) begin
            tick();
            waitCyc++;
        end
        if (!in_ready) begin
            checkOutput("idle_timeout", 32'(in_ready), 32'd1);
            return;
        end

        in_valid = 1'b1;
        in_data  = word;
        tick();
        in_valid = holdValid;
        in_data  = W'($urandom);

        checkOutput("accept_busy", 32'(busy), 32'd1);
`ifdef ZERO_STUFF_COUNT_EN
        checkOutput("stuff_cnt", 32'(stuff_cnt), 32'(expBits.size() - W));
`endif

        j   = 0;
        cyc = 0;
        while (j < expBits.size() && cyc < 200) begin
            case (mode)
                0:       r = 1'b1;
                1:       r = pattern[cyc % 4];
                default: r = ($urandom_range(0, 3) != 0);
            endcase
            out_ready = r;
            checkOutput("out_valid", 32'(out_valid), 32'd1);
            checkOutput("out_bit", 32'(out_bit), 32'(expBits[j]));
            checkOutput("out_last", 32'(out_last), 32'(j == expBits.size() - 1));
            checkOutput("in_ready_low", 32'(in_ready), 32'd0);
            if (holdValid) in_data = W'($urandom);
            tick();
            if (r) j++;
            cyc++;
        end
        if (j < expBits.size()) checkOutput("frame_timeout", 32'(j), 32'(expBits.size()));

        in_valid  = 1'b0;
        out_ready = 1'b0;
        checkOutput("end_valid", 32'(out_valid), 32'd0);
        checkOutput("end_in_ready", 32'(in_ready), 32'd1);
        checkOutput("end_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        #1ms;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        tick();
        tick();
        checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
        checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_out_bit", 32'(out_bit), 32'd0);
        checkOutput("rst_out_last", 32'(out_last), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
`ifdef ZERO_STUFF_COUNT_EN
        checkOutput("rst_stuff_cnt", 32'(stuff_cnt), 32'd0);
`endif
        rst_n = 1'b1;
        tick();

        applyStimulus(5'b10111, 0, 1'b0);
        applyStimulus(5'b11111, 0, 1'b0);
        applyStimulus(5'b00000, 0, 1'b0);
        applyStimulus(5'b01101, 0, 1'b0);
        applyStimulus(5'b11011, 1, 1'b0);

        // Reset while the third bit of 11111 is on the line.
        in_valid  = 1'b1;
        in_data   = 5'b11111;
        tick();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        tick();
        checkOutput("pre_rst_bit3", 32'(out_bit), 32'd1);
        rst_n = 1'b0;
        tick();
        rst_n     = 1'b1;
        out_ready = 1'b0;
        checkOutput("midrst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("midrst_busy", 32'(busy), 32'd0);
        checkOutput("midrst_in_ready", 32'(in_ready), 32'd1);
`ifdef ZERO_STUFF_COUNT_EN
        checkOutput("midrst_stuff_cnt", 32'(stuff_cnt), 32'd0);
`endif
        applyStimulus(5'b10001, 0, 1'b0);

        applyStimulus(5'b11110, 0, 1'b1);
        applyStimulus(W'($urandom), 2, 1'b1);

        for (int n = 0; n < 40; n++) begin
            applyStimulus(W'($urandom), $urandom_range(0, 2), bit'($urandom_range(0, 1)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
